mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin controller for the shared 4:1 mux datapath with 2-bit select and one-hot decode outputs.
- Four requesters each present a data word and a request.
- The block grants one requester at a time, drives the mux select and one-hot grant, and registers the selected data with a valid flag.
- A hold limit bounds how long one requester keeps the mux while others wait.

Parameters:
- DW, 1, data width per requester (the mux datapath is 1 bit wide by default).
- MAX_HOLD, 4, maximum consecutive grant cycles while another requester is pending; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; req[i] belongs to requester i.
- data  input  4*DW  requester data; requester i drives data[i*DW +: DW].
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered mux select, equal to the index of the granted requester.
- dout  output  DW  registered mux output.
- dout_valid  output  1  high when dout holds data from a granted cycle.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (asynchronous, rst=1): gnt=0, sel=0, dout=0, dout_valid=0, busy=0, state=IDLE, ptr=3, hold_cnt=0.
  - ptr=3 makes requester 0 the highest priority after reset.
- Winner search: scan indices ptr+1, ptr+2, ptr+3, ptr+4 (mod 4); the first with req set wins.
- IDLE state:
  - If req==0, stay in IDLE with gnt=0.
  - Otherwise, at the next edge: gnt=onehot(winner), sel=winner, hold_cnt=1, state=GRANT.
- GRANT state, with current index g, evaluated at each edge:
  - Release if req[g]==0, or if hold_cnt==MAX_HOLD and some other req[j] is set (j!=g).
  - On release:
    - ptr<=g.
    - Search again from g+1, using the current req with req[g] excluded.
    - If a winner exists, grant it on the same edge with no idle bubble: gnt/sel update, hold_cnt=1.
    - If there is no winner, go to IDLE with gnt=0.
  - No release, hold_cnt<MAX_HOLD: hold_cnt increments.
  - No release, hold_cnt==MAX_HOLD, no other requester: grant continues and hold_cnt reloads to 1. The counter never exceeds MAX_HOLD.
- Datapath: each edge, dout<=data slice selected by sel if gnt!=0, else dout holds its value; dout_valid<=|gnt.
- Latency:
  - req sampled at edge 0 -> gnt/sel at edge 1 -> dout_valid/dout at edge 2.
  - After a grant drops, dout_valid falls one edge later; dout is never cleared except by reset.
- busy is registered and equals (state==GRANT).
- gnt is always zero or one-hot. sel changes only on edges where gnt changes to a new non-zero value.
- Simultaneous requests are resolved only by ptr rotation, never by fixed index.
- A requester that drops and reasserts on the next cycle is not granted ahead of higher-rotation requesters.
- Reset mid-grant: all registers return to reset values immediately without waiting for a clock edge. Pending requests are re-arbitrated from requester 0 after rst deasserts.
- Data changes on data[] while granted are tracked every cycle; no data latching happens at grant time.

Test Plan:
- Single requester: req=4'b0100 from cycle 0 -> gnt=4'b0100 and sel=2 at edge 1; dout_valid=1 and dout=data[2] at edge 2; busy=1.
- Rotation with MAX_HOLD=4, req=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001, each lasting exactly 4 cycles, with no idle gap between grants.
- Post-reset tie: req=4'b1010 -> gnt=4'b0010 first. Drop req[1] after 2 cycles -> gnt=4'b1000 on the next edge, sel=3.
- Release to idle: a sole requester 0 drops req after 3 cycles -> gnt=0 and busy=0 on the next edge; dout_valid=0 one edge later; dout keeps its last value.
- Lone hog: req=4'b0001 held 12 cycles with MAX_HOLD=4 -> gnt stays 0001 continuously and hold_cnt cycles 1..4. Raise req[2] on a cycle where hold_cnt=4 -> gnt switches to 4'b0100 on the next edge.
- Async reset mid-grant: assert rst between edges while gnt=4'b0100 -> gnt=0, sel=0, dout=0, dout_valid=0 immediately. Release rst with req=4'b0110 -> first grant is 4'b0010.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Bundle between four requesters and the round-robin mux arbiter.
// The master side presents requests and data; the slave side returns grant and muxed data.
interface mux_rr_arbiter_if #(
  parameter int DW = 1
);
  logic [3:0]      req;
  logic [4*DW-1:0] data;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic            busy;

  modport master (
    output req, data,
    input  gnt, sel, dout, dout_valid, busy
  );

  modport slave (
    input  req, data,
    output gnt, sel, dout, dout_valid, busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux: registered one-hot grant and select,
// a registered mux output with a valid flag, and a hold limit when others are waiting.
module mux_rr_arbiter #(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst,
  mux_rr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t        state, state_n;
  logic [1:0]    ptr, ptr_n;
  logic [3:0]    hold_cnt, hold_n;
  logic [3:0]    gnt_r, gnt_n;
  logic [1:0]    sel_r, sel_n;
  logic [DW-1:0] dout_r;
  logic          valid_r;
  logic          busy_r;

  logic [3:0]    others;
  logic          release_g;
  logic [2:0]    pick_idle, pick_rel;

  // Returns {found, index}: first set bit scanning p+1 .. p+4 (mod 4).
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = p + 2'(i);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    gnt_n     = gnt_r;
    sel_n     = sel_r;

    others    = bus.req & ~gnt_r;
    release_g = !bus.req[sel_r] || ((hold_cnt == HOLD_MAX) && (|others));
    pick_idle = pick(bus.req, ptr);
    pick_rel  = pick(others, sel_r);

    case (state)
      IDLE: begin
        gnt_n = '0;
        if (pick_idle[2]) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << pick_idle[1:0];
          sel_n   = pick_idle[1:0];
          hold_n  = 4'd1;
        end
      end
      GRANT: begin
        if (release_g) begin
          ptr_n = sel_r;
          // The releasing requester is excluded, so a drop-and-reassert cannot win straight back.
          if (pick_rel[2]) begin
            gnt_n  = 4'b0001 << pick_rel[1:0];
            sel_n  = pick_rel[1:0];
            hold_n = 4'd1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            hold_n  = '0;
          end
        end else if (hold_cnt == HOLD_MAX) begin
          hold_n = 4'd1;
        end else begin
          hold_n = hold_cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      hold_cnt <= '0;
      gnt_r    <= '0;
      sel_r    <= '0;
      dout_r   <= '0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt_r    <= gnt_n;
      sel_r    <= sel_n;
      busy_r   <= (state_n == GRANT);
      valid_r  <= |gnt_r;
      if (|gnt_r) dout_r <= bus.data[int'(sel_r)*DW +: DW];
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.sel        = sel_r;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = valid_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic, compared every cycle
// against an owner/pointer reference model of the arbitration rules.
module tb_mux_rr_arbiter;

  localparam int DW       = 4;
  localparam int MAX_HOLD = 4;
  localparam int DATA_W   = 4 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux_rr_arbiter_if #(.DW(DW)) bus ();

  mux_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the mux, whom the rotation last served, how long the owner has held.
  int            m_owner;
  int            m_ptr;
  int            m_hold;
  int            m_sel;
  logic [DW-1:0] m_dout;
  bit            m_valid;

  function automatic int scan(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_hold  = 0;
    m_sel   = 0;
    m_dout  = '0;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [DATA_W-1:0] d);
    logic [3:0] rest;
    int w;
    if (m_owner >= 0) m_dout = d[m_owner*DW +: DW];
    m_valid = (m_owner >= 0);
    if (m_owner < 0) begin
      w = scan(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_hold = 1;
      end
    end else begin
      rest = r;
      rest[m_owner] = 1'b0;
      if (!r[m_owner] || (m_hold == MAX_HOLD && rest != 4'b0)) begin
        m_ptr = m_owner;
        w = scan(rest, m_owner);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_hold = 1;
        end else begin
          m_owner = -1; m_hold = 0;
        end
      end else begin
        m_hold = (m_hold == MAX_HOLD) ? 1 : m_hold + 1;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later, then data is refreshed.
  task automatic tick();
    logic [3:0] exp_gnt;
    @(posedge clk);
    model_step(bus.req, bus.data);
    #1;
    exp_gnt = (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner);
    n_checks++;
    if (bus.gnt !== exp_gnt || bus.sel !== 2'(m_sel) || bus.dout !== m_dout ||
        bus.dout_valid !== m_valid || bus.busy !== (m_owner >= 0)) begin
      n_fail++;
      $display("FAIL model t=%0t gnt=%b/%b sel=%0d/%0d dout=%h/%h valid=%b/%b busy=%b/%b (actual/expected)",
               $time, bus.gnt, exp_gnt, bus.sel, m_sel, bus.dout, m_dout,
               bus.dout_valid, m_valid, bus.busy, (m_owner >= 0));
    end
    bus.data = DATA_W'($urandom);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = 4'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req  = 4'b0;
    bus.data = '0;
    model_reset();
    #12;
    n_checks++;
    if (bus.gnt !== 4'b0 || bus.sel !== 2'd0 || bus.dout !== '0 ||
        bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset gnt=%b sel=%0d dout=%h valid=%b busy=%b, required all zero",
               bus.gnt, bus.sel, bus.dout, bus.dout_valid, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_d;
    apply_reset();
    bus.req = 4'b0100;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant gnt=%b sel=%0d busy=%b, required 0100 2 1", bus.gnt, bus.sel, bus.busy);
    end
    exp_d = bus.data[2*DW +: DW];
    tick();
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== exp_d) begin
      n_fail++;
      $display("FAIL single_data valid=%b dout=%h, required 1 %h", bus.dout_valid, bus.dout, exp_d);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    apply_reset();
    bus.req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      exp_g = 4'b0001 << ((c / MAX_HOLD) % 4);
      n_checks++;
      if (bus.gnt !== exp_g) begin
        n_fail++;
        $display("FAIL rotation cycle=%0d gnt=%b, required %b", c, bus.gnt, exp_g);
      end
    end
  endtask

  task automatic test_tie();
    apply_reset();
    bus.req = 4'b1010;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL tie_first gnt=%b, required 0010", bus.gnt);
    end
    tick();
    bus.req = 4'b1000;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3) begin
      n_fail++;
      $display("FAIL tie_handover gnt=%b sel=%0d, required 1000 3", bus.gnt, bus.sel);
    end
  endtask

  task automatic test_release_idle();
    logic [DW-1:0] last;
    apply_reset();
    bus.req = 4'b0001;
    repeat (3) tick();
    bus.req = 4'b0000;
    last = bus.data[DW-1:0];
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.dout_valid !== 1'b1 || bus.dout !== last) begin
      n_fail++;
      $display("FAIL release_edge gnt=%b busy=%b valid=%b dout=%h, required 0000 0 1 %h",
               bus.gnt, bus.busy, bus.dout_valid, bus.dout, last);
    end
    tick();
    n_checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== last) begin
      n_fail++;
      $display("FAIL release_after valid=%b dout=%h, required 0 %h", bus.dout_valid, bus.dout, last);
    end
  endtask

  task automatic test_lone_hog();
    int budget;
    apply_reset();
    bus.req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++;
      if (bus.gnt !== 4'b0001) begin
        n_fail++;
        $display("FAIL hog_hold cycle=%0d gnt=%b, required 0001", c, bus.gnt);
      end
    end
    budget = 2 * MAX_HOLD;
    while (m_hold != MAX_HOLD && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (budget == 0 && m_hold != MAX_HOLD) begin
      n_fail++;
      $display("FAIL hog_budget hold=%0d, required %0d within budget", m_hold, MAX_HOLD);
    end
    bus.req = 4'b0101;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2) begin
      n_fail++;
      $display("FAIL hog_preempt gnt=%b sel=%0d, required 0100 2", bus.gnt, bus.sel);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.req = 4'b0100;
    tick();
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.gnt !== 4'b0 || bus.sel !== 2'd0 || bus.dout !== '0 || bus.dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset gnt=%b sel=%0d dout=%h valid=%b, required all zero",
               bus.gnt, bus.sel, bus.dout, bus.dout_valid);
    end
    bus.req = 4'b0110;
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL async_rearb gnt=%b, required 0010", bus.gnt);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_tie();
    test_release_idle();
    test_lone_hog();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
